seg7_hex_reader: RTL and testbench
==================================

# seg7_hex_reader

Recovers hex digits from a multiplexed 7-segment display drive: it samples the segment and digit-select lines, waits until each digit's pattern has been stable, decodes the pattern back to a 4-bit value, and presents a full frame of DIGITS nibbles on a valid/ready handshake. It is the inverse of the hex-to-segment decoders and is used to check or loop back display outputs in our synthesized designs.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digits (1..8).
- STABLE_CYCLES, 8: consecutive identical samples required before a digit is captured (2..255).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high.
- seg  input  7  segment lines {g,f,e,d,c,b,a}, bit 0 = a, active-high.
- dig_sel  input  DIGITS  digit enable, one-hot; bit i = digit i.
- frame_ready  input  1  consumer accepts frame.
- frame_valid  output  1  frame_value/frame_err hold a complete frame.
- frame_value  output  4*DIGITS  nibble i at [4i+3:4i].
- frame_err  output  DIGITS  bit i set = digit i pattern not a legal hex glyph.

## Operation
- Input stage: seg and dig_sel are registered once (s_seg, s_sel) before any use.
- Stability: counter stab_cnt (8 bits). Each cycle, if {s_seg,s_sel} equals the previous registered sample and s_sel is one-hot, stab_cnt increments, saturating at STABLE_CYCLES; otherwise stab_cnt clears to 1 if s_sel is one-hot, else to 0.
- Capture: when stab_cnt reaches STABLE_CYCLES (transition edge only, once per stable run), digit i = index of s_sel is decoded: nibble[i] and err[i] are written and seen[i] is set. A re-capture of an already-seen digit overwrites it.
- Legal glyphs (hex → seg): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other pattern: nibble = 0, err = 1.
- FSM states:
  - COLLECT: capture enabled. When seen becomes all-ones, go to PRESENT next cycle.
  - PRESENT: frame_valid = 1; frame_value/frame_err are frozen and captures are ignored (the stability counter keeps running). When frame_ready = 1, return to COLLECT and clear seen.
- Illegal dig_sel (zero or multi-hot) never captures and never affects seen.

## Timing
- Reset values: frame_valid = 0, frame_value = 0, frame_err = 0, seen = 0, stab_cnt = 0, state = COLLECT. Reset in PRESENT drops frame_valid in the next cycle and discards the frame.
- Latency: capture of a digit occurs in the cycle after the STABLE_CYCLES-th consecutive identical sample on the input pins. That is STABLE_CYCLES+1 clocks after the pins settle.
- frame_valid rises one cycle after the final digit's capture.
- Handshake:
  - Transfer occurs when frame_valid & frame_ready are both high at a clock edge.
  - frame_valid stays high and outputs are held stable until the transfer.
  - frame_ready while frame_valid = 0 is ignored.
- Simultaneous events:
  - A capture that coincides with the transfer cycle is ignored, because the state is still PRESENT.
  - The next frame starts collecting in the following cycle.
- Back-to-back frames: minimum frame_valid-low gap is one cycle.

## Structure
- Package seg7_pkg: the 16 glyph constants SEG_0..SEG_F (7-bit) and the bit-index constants SEG_A..SEG_G. It is shared with the existing segment decoders.
- Sub-module seg7_pattern_decode: a combinational 7-bit pattern to {err, nibble[3:0]} lookup, instantiated once on s_seg.
- The top level holds the input registers, the stability counter, the seen/nibble/err storage, and the 2-state FSM.

## Test plan
- Reset, then drive digits 0..3 with 3F, 06, 5B, 4F, each for 10 cycles, with frame_ready = 1 → one frame with frame_value = 16'h3210, frame_err = 0. frame_valid rises 1 cycle after digit 3's capture.
- Hold a digit for exactly STABLE_CYCLES−1 cycles, then change it → no capture and seen unchanged. Hold for STABLE_CYCLES → capture 1 cycle after the 8th sample.
- Drive glyph 7F on digit 2 with pattern 0x01 (illegal) and all others legal → frame_err = 4'b0100 and nibble 2 = 0.
- frame_ready = 0 for 50 cycles while new patterns keep arriving → frame_valid stays 1 and the frame is unchanged. Raise frame_ready → transfer, and the next frame reflects only post-transfer captures.
- dig_sel = 0 and dig_sel = 4'b0011 for 20 cycles each → no captures and frame_valid stays 0.
- Assert reset during PRESENT → frame_valid = 0 and frame_value = 0 on the next cycle, and seen is cleared.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants (active-high, bit 0 = segment a) and the
// reader's state encoding.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A_GLYPH = 7'h77;
   localparam logic [6:0] SEG_B_GLYPH = 7'h7C;
   localparam logic [6:0] SEG_C_GLYPH = 7'h39;
   localparam logic [6:0] SEG_D_GLYPH = 7'h5E;
   localparam logic [6:0] SEG_E_GLYPH = 7'h79;
   localparam logic [6:0] SEG_F_GLYPH = 7'h71;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PRESENT = 1'b1
   } reader_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment decoder: any pattern that is not
// one of the sixteen glyphs decodes to nibble 0 with err set.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       err
);

   always_comb begin
      nibble = 4'h0;
      err    = 1'b0;
      case (pattern)
         SEG_0:       nibble = 4'h0;
         SEG_1:       nibble = 4'h1;
         SEG_2:       nibble = 4'h2;
         SEG_3:       nibble = 4'h3;
         SEG_4:       nibble = 4'h4;
         SEG_5:       nibble = 4'h5;
         SEG_6:       nibble = 4'h6;
         SEG_7:       nibble = 4'h7;
         SEG_8:       nibble = 4'h8;
         SEG_9:       nibble = 4'h9;
         SEG_A_GLYPH: nibble = 4'hA;
         SEG_B_GLYPH: nibble = 4'hB;
         SEG_C_GLYPH: nibble = 4'hC;
         SEG_D_GLYPH: nibble = 4'hD;
         SEG_E_GLYPH: nibble = 4'hE;
         SEG_F_GLYPH: nibble = 4'hF;
         default:     err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_hex_reader.sv
// Recovers a frame of hex digits from a multiplexed 7-segment drive once each
// digit's pattern has been stable, and hands it out on a valid/ready handshake.
module seg7_hex_reader
   import seg7_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     dig_sel,
   input  logic                  frame_ready,
   output logic                  frame_valid,
   output logic [4*DIGITS-1:0]   frame_value,
   output logic [DIGITS-1:0]     frame_err
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

   logic [6:0]              s_seg, p_seg;
   logic [DIGITS-1:0]       s_sel, p_sel;
   logic [7:0]              stab_cnt, stab_next;
   logic                    sel_onehot;
   logic                    capture;
   logic [3:0]              dec_nib;
   logic                    dec_err;
   logic [DIGITS-1:0]       seen;
   logic [DIGITS-1:0][3:0]  nib_q;
   logic [DIGITS-1:0]       err_q;
   reader_state_t           state;

   // Pins are registered once; p_* is the previous registered sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_seg <= '0;
         s_sel <= '0;
         p_seg <= '0;
         p_sel <= '0;
      end else begin
         s_seg <= seg;
         s_sel <= dig_sel;
         p_seg <= s_seg;
         p_sel <= s_sel;
      end
   end

   assign sel_onehot = (s_sel != '0) && ((s_sel & (s_sel - DIGITS'(1))) == '0);

   always_comb begin
      stab_next = 8'd0;
      if (sel_onehot) begin
         if (s_seg == p_seg && s_sel == p_sel)
            stab_next = (stab_cnt >= STABLE_MAX) ? STABLE_MAX : stab_cnt + 8'd1;
         else
            stab_next = 8'd1;
      end
   end

   // Fires only on the edge into saturation, so one capture per stable run.
   assign capture = (state == ST_COLLECT) && (stab_next == STABLE_MAX) &&
                    (stab_cnt != STABLE_MAX);

   seg7_pattern_decode u_decode (
      .pattern (s_seg),
      .nibble  (dec_nib),
      .err     (dec_err)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_COLLECT;
         frame_valid <= 1'b0;
         seen        <= '0;
         nib_q       <= '0;
         err_q       <= '0;
         stab_cnt    <= 8'd0;
      end else begin
         stab_cnt <= stab_next;
         case (state)
            ST_COLLECT: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (capture && s_sel[i]) begin
                     nib_q[i] <= dec_nib;
                     err_q[i] <= dec_err;
                     seen[i]  <= 1'b1;
                  end
               end
               if (&seen) begin
                  state       <= ST_PRESENT;
                  frame_valid <= 1'b1;
               end
            end
            ST_PRESENT: begin
               // Storage is frozen here; it doubles as the presented frame.
               if (frame_ready) begin
                  state       <= ST_COLLECT;
                  frame_valid <= 1'b0;
                  seen        <= '0;
               end
            end
            default: begin
               state       <= ST_COLLECT;
               frame_valid <= 1'b0;
            end
         endcase
      end
   end

   assign frame_value = nib_q;
   assign frame_err   = err_q;

endmodule

// File: tb/tb_seg7_hex_reader.sv
// Randomized and directed stimulus against a pin-sample-level reference model;
// expected frames go through a scoreboard queue checked by a monitor.
module tb_seg7_hex_reader;

   localparam int DIGITS = 4;
   localparam int SC     = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  seg;
   logic [3:0]  dig_sel;
   logic        frame_ready;
   logic        frame_valid;
   logic [15:0] frame_value;
   logic [3:0]  frame_err;

   int total = 0;
   int bad   = 0;

   seg7_hex_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
      .clk         (clk),
      .reset       (reset),
      .seg         (seg),
      .dig_sel     (dig_sel),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .frame_value (frame_value),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      logic [15:0] val;
      logic [3:0]  err;
   } frame_t;
   frame_t sbq[$];

   // reference model state
   bit          m_valid = 0;
   bit [3:0]    m_seen = 0;
   logic [15:0] m_val = '0;
   logic [3:0]  m_err = '0;
   int          run = 0;
   bit          prev_ok = 0;
   logic [6:0]  prev_seg;
   logic [3:0]  prev_sel;
   bit          pending = 0;
   int          pend_idx;
   logic [6:0]  pend_seg;
   bit          mon_en = 0;

   function automatic void ref_decode(input logic [6:0] p, output logic [3:0] n, output logic e);
      n = 4'h0;
      e = 1'b1;
      for (int k = 0; k < 16; k++)
         if (glyph[k] == p) begin
            n = 4'(k);
            e = 1'b0;
         end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a digit is captured on the edge after the SC-th identical one-hot
   // pin sample; a full frame is presented on the edge after the last capture.
   always @(posedge clk) begin
      logic [3:0] n;
      logic       e;
      bit         full;
      if (reset) begin
         m_valid = 0; m_seen = 0; m_val = '0; m_err = '0;
         run = 0; prev_ok = 0; pending = 0;
      end else begin
         if (m_valid) begin
            if (frame_ready) begin
               m_valid = 0;
               m_seen  = 0;
            end
         end else begin
            full = (m_seen == 4'hF);
            if (pending) begin
               ref_decode(pend_seg, n, e);
               m_val[pend_idx*4 +: 4] = n;
               m_err[pend_idx]        = e;
               m_seen[pend_idx]       = 1'b1;
            end
            if (full) begin
               m_valid = 1;
               sbq.push_back('{val: m_val, err: m_err});
            end
         end
         if ($countones(dig_sel) != 1)
            run = 0;
         else if (prev_ok && seg == prev_seg && dig_sel == prev_sel)
            run++;
         else
            run = 1;
         prev_ok  = 1;
         prev_seg = seg;
         prev_sel = dig_sel;
         pending  = (run == SC);
         if (pending) begin
            pend_seg = seg;
            for (int k = 0; k < DIGITS; k++)
               if (dig_sel[k]) pend_idx = k;
         end
      end
   end

   // Monitor
   bit          was_valid = 0;
   logic [15:0] held_val;
   logic [3:0]  held_err;
   always @(negedge clk) begin
      frame_t f;
      if (mon_en) begin
         check("valid_timing", {31'd0, frame_valid}, {31'd0, m_valid});
         if (frame_valid && !was_valid) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_frame: got %h/%b expected none", frame_value, frame_err);
            end else begin
               f = sbq.pop_front();
               check("frame_value", {16'd0, frame_value}, {16'd0, f.val});
               check("frame_err", {28'd0, frame_err}, {28'd0, f.err});
            end
            held_val = frame_value;
            held_err = frame_err;
         end else if (frame_valid && was_valid) begin
            check("hold_value", {12'd0, frame_err, frame_value}, {12'd0, held_err, held_val});
         end
         was_valid = frame_valid;
      end
   end

   task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
      seg     = s;
      dig_sel = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic full_frame(input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3);
      drive(g0, 4'b0001, 10);
      drive(g1, 4'b0010, 10);
      drive(g2, 4'b0100, 10);
      drive(g3, 4'b1000, 10);
   endtask

   initial begin
      reset = 1'b1; frame_ready = 1'b0; seg = '0; dig_sel = '0;
      @(negedge clk);
      mon_en = 1;
      @(negedge clk);
      check("reset_valid", {31'd0, frame_valid}, 32'd0);
      check("reset_value", {16'd0, frame_value}, 32'd0);
      check("reset_err", {28'd0, frame_err}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // basic frame 3210
      frame_ready = 1'b1;
      full_frame(7'h3F, 7'h06, 7'h5B, 7'h4F);
      drive(7'h00, 4'b0000, 5);

      // stability boundary: SC-1 then SC
      drive(7'h66, 4'b0001, SC - 1);
      drive(7'h6D, 4'b0010, SC);
      drive(7'h00, 4'b0000, 3);
      drive(7'h7D, 4'b0100, 10);
      drive(7'h07, 4'b1000, 10);
      drive(7'h66, 4'b0001, 10);
      drive(7'h00, 4'b0000, 5);

      // illegal glyph on digit 2
      full_frame(7'h7F, 7'h7F, 7'h01, 7'h7F);
      drive(7'h00, 4'b0000, 5);

      // back-pressure while new patterns arrive
      frame_ready = 1'b0;
      full_frame(7'h77, 7'h7C, 7'h39, 7'h5E);
      drive(7'h00, 4'b0000, 2);
      for (int i = 0; i < 5; i++)
         drive(glyph[$urandom_range(15)], 4'(1 << $urandom_range(3)), 10);
      frame_ready = 1'b1;
      full_frame(7'h79, 7'h71, 7'h6F, 7'h3F);
      drive(7'h00, 4'b0000, 5);

      // illegal selects never capture
      drive(7'h3F, 4'b0000, 20);
      drive(7'h06, 4'b0011, 20);

      // reset while presenting
      frame_ready = 1'b0;
      full_frame(7'h06, 7'h5B, 7'h4F, 7'h66);
      drive(7'h00, 4'b0000, 3);
      reset = 1'b1;
      @(negedge clk);
      check("rst_present_valid", {31'd0, frame_valid}, 32'd0);
      check("rst_present_value", {16'd0, frame_value}, 32'd0);
      reset = 1'b0;
      frame_ready = 1'b1;
      drive(7'h3F, 4'b0001, 10);
      drive(7'h3F, 4'b0010, 10);
      drive(7'h3F, 4'b0100, 10);
      drive(7'h00, 4'b0000, 5);
      check("seen_cleared", {31'd0, frame_valid}, 32'd0);
      drive(7'h3F, 4'b1000, 10);
      drive(7'h00, 4'b0000, 5);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         logic [6:0] s;
         logic [3:0] d;
         s = ($urandom_range(9) < 8) ? glyph[$urandom_range(15)] : 7'($urandom);
         d = ($urandom_range(19) < 17) ? 4'(1 << $urandom_range(3)) : 4'($urandom);
         frame_ready = ($urandom_range(9) < 7);
         drive(s, d, $urandom_range(12, 1));
      end

      frame_ready = 1'b1;
      drive(7'h00, 4'b0000, 20);
      check("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
